// File: rtl/pyr_pkg.sv
// Shared constants for the 2:1 pyramid downsampler: default pixel width,
// MODE encodings and the width of the 2x2 block sum.
package pyr_pkg;

    localparam int PIX_W_DEF = 8;

    localparam int MODE_AVG = 0;
    localparam int MODE_DEC = 1;

    // A 2x2 sum of PIX_W-bit pixels needs two extra bits.
    function automatic int sum_width(input int pix_w);
        return pix_w + 2;
    endfunction

    localparam int SUM_W_DEF = PIX_W_DEF + 2;

endpackage

// File: rtl/pyramid_downsampler_if.sv
// Pixel stream bundle for the downsampler: input stream (recv_*) and reduced
// output stream (send_*). The slave modport is the downsampler side.
interface pyramid_downsampler_if
    import pyr_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
);
    logic [PIX_W-1:0] recv_msg;
    logic             recv_val;
    logic             recv_rdy;
    logic [PIX_W-1:0] send_msg;
    logic             send_val;
    logic             send_rdy;
    logic             send_last;

    modport master (
        output recv_msg, recv_val, send_rdy,
        input  recv_rdy, send_msg, send_val, send_last
    );

    modport slave (
        input  recv_msg, recv_val, send_rdy,
        output recv_rdy, send_msg, send_val, send_last
    );
endinterface

// File: rtl/pyr_line_store.sv
// One-line buffer of horizontal pair sums: single write port, asynchronous read
// so it maps onto distributed RAM.
module pyr_line_store
    import pyr_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int DATA_W = PIX_W_DEF + 1,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pyramid_downsampler.sv
// Streaming 2:1 image-pyramid reducer (2x2 mean or bottom-right decimation).
// Define PYR_DS_ROUND_EN to round the 2x2 mean half up instead of truncating.
module pyramid_downsampler
    import pyr_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = PIX_W_DEF,
    parameter int MODE  = MODE_AVG
) (
    input  logic clk,
    input  logic reset,
    pyramid_downsampler_if.slave bus
);
    localparam int SUM_W  = sum_width(PIX_W);
    localparam int PAIR_W = PIX_W + 1;
    localparam int CW     = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW     = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int DEPTH  = IMG_W / 2;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    generate
        if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_width
            $error("pyramid_downsampler: IMG_W must be even and at least 2");
        end
        if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_height
            $error("pyramid_downsampler: IMG_H must be even and at least 2");
        end
        if (MODE != MODE_AVG && MODE != MODE_DEC) begin : g_bad_mode
            $error("pyramid_downsampler: MODE must be MODE_AVG or MODE_DEC");
        end
    endgenerate

    logic [CW-1:0]     col_reg, col_next;
    logic [RW-1:0]     row_reg, row_next;
    logic [PAIR_W-1:0] hsum_reg, hsum_next;
    logic              send_val_reg, send_val_next;
    logic [PIX_W-1:0]  send_msg_reg, send_msg_next;
    logic              send_last_reg, send_last_next;

    logic              recv_rdy;
    logic              accept;
    logic              col_odd, row_odd, col_last, row_last;
    logic              block_done;
    logic [PAIR_W-1:0] pair_sum;
    logic [PIX_W-1:0]  blk_msg;
    logic              ls_wr_en;

    // Ready depends only on the output register, never on recv_val.
    assign recv_rdy   = !send_val_reg || bus.send_rdy;
    assign accept     = bus.recv_val && recv_rdy;
    assign col_odd    = col_reg[0];
    assign row_odd    = row_reg[0];
    assign col_last   = (col_reg == COL_MAX);
    assign row_last   = (row_reg == ROW_MAX);
    assign block_done = accept && row_odd && col_odd;
    assign pair_sum   = hsum_reg + {1'b0, bus.recv_msg};

    generate
        if (MODE == MODE_AVG) begin : g_avg
            logic [AW-1:0]     ls_addr;
            logic [PAIR_W-1:0] ls_rd_data;
            logic [SUM_W-1:0]  total;

            assign ls_addr  = AW'(col_reg >> 1);
            assign ls_wr_en = accept && !row_odd && col_odd;
            assign total    = {1'b0, ls_rd_data} + {1'b0, pair_sum};

            pyr_line_store #(
                .DEPTH  (DEPTH),
                .DATA_W (PAIR_W),
                .AW     (AW)
            ) u_line_store (
                .clk     (clk),
                .wr_en   (ls_wr_en),
                .wr_addr (ls_addr),
                .wr_data (pair_sum),
                .rd_addr (ls_addr),
                .rd_data (ls_rd_data)
            );

`ifdef PYR_DS_ROUND_EN
            logic [SUM_W-1:0] total_rnd;
            // Cannot overflow: 4*max + 2 still fits in SUM_W bits.
            assign total_rnd = total + SUM_W'(2);
            assign blk_msg   = total_rnd[SUM_W-1:2];
`else
            assign blk_msg   = total[SUM_W-1:2];
`endif
        end else begin : g_dec
            // Decimation keeps the bottom-right pixel; the line store is unused.
            assign ls_wr_en = 1'b0;
            assign blk_msg  = bus.recv_msg;
        end
    endgenerate

    always_comb begin
        col_next  = col_reg;
        row_next  = row_reg;
        hsum_next = hsum_reg;
        if (accept) begin
            hsum_next = col_odd ? pair_sum : {1'b0, bus.recv_msg};
            if (col_last) begin
                col_next = '0;
                row_next = row_last ? '0 : row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    always_comb begin
        send_val_next  = send_val_reg;
        send_msg_next  = send_msg_reg;
        send_last_next = send_last_reg;
        if (block_done) begin
            send_val_next  = 1'b1;
            send_msg_next  = blk_msg;
            send_last_next = row_last && col_last;
        end else if (bus.send_rdy) begin
            send_val_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_reg       <= '0;
            row_reg       <= '0;
            hsum_reg      <= '0;
            send_val_reg  <= 1'b0;
            send_msg_reg  <= '0;
            send_last_reg <= 1'b0;
        end else begin
            col_reg       <= col_next;
            row_reg       <= row_next;
            hsum_reg      <= hsum_next;
            send_val_reg  <= send_val_next;
            send_msg_reg  <= send_msg_next;
            send_last_reg <= send_last_next;
        end
    end

    assign bus.recv_rdy  = recv_rdy;
    assign bus.send_val  = send_val_reg;
    assign bus.send_msg  = send_msg_reg;
    assign bus.send_last = send_last_reg;

endmodule

// File: tb/tb_pyramid_downsampler.sv
// Bench for pyramid_downsampler: 4x2 vector table in both modes, reset and
// backpressure sequences, and three random 64x64 frames under random send_rdy.
module tb_pyramid_downsampler;
    import pyr_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    pyramid_downsampler_if #(.PIX_W(8)) ifa ();
    pyramid_downsampler_if #(.PIX_W(8)) ifb ();
    pyramid_downsampler_if #(.PIX_W(8)) ifc ();

    pyramid_downsampler #(.IMG_W(4), .IMG_H(2), .PIX_W(8), .MODE(MODE_AVG)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    pyramid_downsampler #(.IMG_W(4), .IMG_H(2), .PIX_W(8), .MODE(MODE_DEC)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));
    pyramid_downsampler #(.IMG_W(64), .IMG_H(64), .PIX_W(8), .MODE(MODE_AVG)) dut_c (
        .clk(clk), .reset(reset), .bus(ifc));

    logic [7:0] s_msg;
    logic       s_val, s_rdy;
    logic [7:0] c_msg;
    logic       c_val, c_rdy;
    logic       big_on;

    assign ifa.recv_msg = s_msg;
    assign ifa.recv_val = s_val;
    assign ifa.send_rdy = s_rdy;
    assign ifb.recv_msg = s_msg;
    assign ifb.recv_val = s_val;
    assign ifb.send_rdy = s_rdy;
    assign ifc.recv_msg = c_msg;
    assign ifc.recv_val = c_val;
    assign ifc.send_rdy = c_rdy;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok   %s: %0d", name, act);
        end
    endtask

    // Output capture for the small instances: entry = {last, msg}.
    int  qa[$];
    int  qb[$];
    bit  we_seen_b = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (ifa.send_val && ifa.send_rdy)
                qa.push_back((int'(ifa.send_last) << 8) | int'(ifa.send_msg));
            if (ifb.send_val && ifb.send_rdy)
                qb.push_back((int'(ifb.send_last) << 8) | int'(ifb.send_msg));
        end
        if (dut_b.ls_wr_en) we_seen_b = 1'b1;
    end

    // Random 30% ready for the large instance.
    always @(posedge clk) begin
        #1;
        c_rdy = big_on ? ($urandom_range(99) < 30) : 1'b0;
    end

    // Scoreboard and stall-stability monitor for the large instance.
    int         exp_c[$];
    int         c_out      = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_msg   = '0;
    logic       prev_last  = 1'b0;

    always @(negedge clk) begin
        if (!reset && big_on) begin
            if (prev_stall)
                check("big_stall_hold",
                      {ifc.send_val, ifc.send_last, ifc.send_msg},
                      {1'b1, prev_last, prev_msg});
            if (ifc.send_val && ifc.send_rdy) begin
                check("big_msg", int'(ifc.send_msg),
                      (exp_c.size() > 0) ? exp_c.pop_front() : -1);
                check("big_last", int'(ifc.send_last), ((c_out % 1024) == 1023) ? 1 : 0);
                c_out++;
            end
            prev_stall = ifc.send_val && !ifc.send_rdy;
            prev_msg   = ifc.send_msg;
            prev_last  = ifc.send_last;
        end
    end

    task automatic push_s(input logic [7:0] p);
        int n = 0;
        s_msg = p;
        s_val = 1'b1;
        @(negedge clk);
        while (!ifa.recv_rdy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) check("push_s_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_val = 1'b0;
    endtask

    task automatic push_c(input logic [7:0] p, output bit timed_out);
        int n = 0;
        timed_out = 1'b0;
        c_msg = p;
        c_val = 1'b1;
        @(negedge clk);
        while (!ifc.recv_rdy && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) timed_out = 1'b1;
        @(posedge clk);
        #1;
        c_val = 1'b0;
    endtask

    typedef struct {
        logic [63:0] pix;      // pixel i of the 4x2 frame at pix[8*i +: 8]
        logic [15:0] exp_avg;  // {second, first} output, MODE_AVG
        logic [15:0] exp_dec;  // {second, first} output, MODE_DEC
    } vec_t;

    function automatic logic [63:0] mk(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic send_frame(input logic [63:0] pix);
        for (int i = 0; i < 8; i++) push_s(pix[8*i +: 8]);
    endtask

    task automatic check_pair(input string tag, input int q0, input int q1, input int qsz,
                              input logic [15:0] expv);
        check({tag, "_count"}, qsz, 2);
        check({tag, "_out0"}, q0, {24'd0, expv[7:0]});
        check({tag, "_out1"}, q1, 256 | {24'd0, expv[15:8]});
    endtask

    task automatic check_queues(input string tag, input logic [15:0] ea, input logic [15:0] eb);
        check_pair({tag, "_avg"}, (qa.size() > 0) ? qa[0] : -1, (qa.size() > 1) ? qa[1] : -1,
                   qa.size(), ea);
        check_pair({tag, "_dec"}, (qb.size() > 0) ? qb[0] : -1, (qb.size() > 1) ? qb[1] : -1,
                   qb.size(), eb);
    endtask

    vec_t vecs[5];
    logic [7:0] fr [64][64];

    initial begin
`ifdef PYR_DS_ROUND_EN
        vecs[0] = '{mk(10, 20, 30, 40, 50, 60, 70, 80),        {8'd55, 8'd35},   {8'd80, 8'd60}};
        vecs[1] = '{mk(1, 2, 255, 255, 2, 2, 255, 255),        {8'd255, 8'd2},   {8'd255, 8'd2}};
        vecs[2] = '{mk(100, 101, 0, 3, 102, 103, 1, 1),        {8'd1, 8'd102},   {8'd1, 8'd103}};
        vecs[3] = '{mk(0, 0, 0, 0, 0, 0, 0, 0),                {8'd0, 8'd0},     {8'd0, 8'd0}};
        vecs[4] = '{mk(255, 0, 0, 255, 0, 255, 255, 0),        {8'd128, 8'd128}, {8'd0, 8'd255}};
`else
        vecs[0] = '{mk(10, 20, 30, 40, 50, 60, 70, 80),        {8'd55, 8'd35},   {8'd80, 8'd60}};
        vecs[1] = '{mk(1, 2, 255, 255, 2, 2, 255, 255),        {8'd255, 8'd1},   {8'd255, 8'd2}};
        vecs[2] = '{mk(100, 101, 0, 3, 102, 103, 1, 1),        {8'd1, 8'd101},   {8'd1, 8'd103}};
        vecs[3] = '{mk(0, 0, 0, 0, 0, 0, 0, 0),                {8'd0, 8'd0},     {8'd0, 8'd0}};
        vecs[4] = '{mk(255, 0, 0, 255, 0, 255, 255, 0),        {8'd127, 8'd127}, {8'd0, 8'd255}};
`endif
        reset  = 1'b1;
        s_msg  = '0; s_val = 1'b0; s_rdy = 1'b1;
        c_msg  = '0; c_val = 1'b0;
        big_on = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_send_val", int'(ifa.send_val), 0);
        check("reset_send_msg", int'(ifa.send_msg), 0);
        check("reset_send_last", int'(ifa.send_last), 0);
        check("reset_recv_rdy", int'(ifa.recv_rdy), 1);
        check("reset_col", int'(dut_a.col_reg), 0);
        @(posedge clk); #1;

        // Table of 4x2 frames, back to back, send_rdy held high
        for (int v = 0; v < 5; v++) begin
            qa.delete(); qb.delete();
            send_frame(vecs[v].pix);
            repeat (3) @(negedge clk);
            check_queues($sformatf("vec%0d", v), vecs[v].exp_avg, vecs[v].exp_dec);
            @(posedge clk); #1;
        end
        check("dec_line_store_we", int'(we_seen_b), 0);

        // Reset mid-frame with an output pending
        s_rdy = 1'b0;
        for (int i = 0; i < 6; i++) push_s(8'd200);
        @(negedge clk);
        check("pre_reset_pending", int'(ifa.send_val), 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_reset_send_val", int'(ifa.send_val), 0);
        check("post_reset_col", int'(dut_a.col_reg), 0);
        @(posedge clk); #1;
        s_rdy = 1'b1;
        qa.delete(); qb.delete();
        send_frame(vecs[0].pix);
        repeat (3) @(negedge clk);
        check_queues("after_reset", vecs[0].exp_avg, vecs[0].exp_dec);
        @(posedge clk); #1;

        // Backpressure: pending output freezes input, release pops and accepts together
        qa.delete(); qb.delete();
        s_rdy = 1'b0;
        for (int i = 0; i < 6; i++) push_s(8'(10 * (i + 1)));
        s_msg = 8'd70; s_val = 1'b1;
        @(negedge clk);
        check("bp_recv_rdy_low", int'(ifa.recv_rdy), 0);
        check("bp_send_val", int'(ifa.send_val), 1);
        check("bp_send_msg", int'(ifa.send_msg), 35);
        repeat (3) @(negedge clk);
        check("bp_col_frozen", int'(dut_a.col_reg), 2);
        check("bp_row_frozen", int'(dut_a.row_reg), 1);
        check("bp_msg_held", int'(ifa.send_msg), 35);
        check("bp_dec_msg_held", int'(ifb.send_msg), 60);
        @(posedge clk); #1 s_rdy = 1'b1;
        @(negedge clk);
        check("bp_recv_rdy_release", int'(ifa.recv_rdy), 1);
        @(posedge clk); #1 s_val = 1'b0;
        @(negedge clk);
        check("bp_col_advanced", int'(dut_a.col_reg), 3);
        check("bp_popped", int'(ifa.send_val), 0);
        @(posedge clk); #1;
        push_s(8'd80);
        repeat (3) @(negedge clk);
        check_queues("backpressure", vecs[0].exp_avg, vecs[0].exp_dec);
        @(posedge clk); #1;

        // Three back-to-back random 64x64 frames, random send_rdy
        big_on = 1'b1;
        begin : big_test
            bit to;
            for (int f = 0; f < 3; f++) begin
                for (int r = 0; r < 64; r++)
                    for (int c = 0; c < 64; c++)
                        fr[r][c] = 8'($urandom_range(255));
                for (int r = 0; r < 64; r += 2)
                    for (int c = 0; c < 64; c += 2) begin
                        int sum;
                        sum = int'(fr[r][c]) + int'(fr[r][c+1]) + int'(fr[r+1][c]) + int'(fr[r+1][c+1]);
`ifdef PYR_DS_ROUND_EN
                        exp_c.push_back((sum + 2) >> 2);
`else
                        exp_c.push_back(sum >> 2);
`endif
                    end
                for (int r = 0; r < 64; r++)
                    for (int c = 0; c < 64; c++) begin
                        push_c(fr[r][c], to);
                        if (to) begin
                            check("big_push_timeout", 0, 1);
                            disable big_test;
                        end
                    end
            end
        end
        for (int n = 0; n < 4000 && c_out < 3072; n++) @(negedge clk);
        check("big_total_outputs", c_out, 3072);
        @(posedge clk); #1 big_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
